// File: rtl/ram_line_responder_pkg.sv
// Shared state type, default widths and helper functions for the RAM-side line responder.
package ram_if_pkg;

  localparam int DEF_ADDR_SIZE  = 13;
  localparam int DEF_WORD_SIZE  = 16;
  localparam int DEF_LINE_WIDTH = 64;

  typedef enum logic [2:0] {
    IDLE,
    WR_COLLECT,
    WR_ACK,
    RD_WAIT,
    RD_BURST
  } ram_state_e;

  function automatic int beats_of(input int lineWidth, input int wordSize);
    return lineWidth / wordSize;
  endfunction

  // Fill for never-written lines: beat index, one zero bit, then the line address.
  function automatic logic [63:0] pattern_beat(input logic [63:0] addr, input logic [1:0] k,
                                               input int addrSize);
    return ({62'd0, k} << (addrSize + 1)) | addr;
  endfunction

endpackage

// File: rtl/ram_line_responder_if.sv
// Cache-to-RAM line request/response bundle; the cache side is the master.
interface ram_line_responder_if
  import ram_if_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int WORD_SIZE = DEF_WORD_SIZE
) ();

  logic                 ram_avalid;
  logic                 ram_rnw;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [WORD_SIZE-1:0] ram_wdata;
  logic [WORD_SIZE-1:0] ram_rdata;
  logic                 ram_ack;

  modport master (
    output ram_avalid, ram_rnw, ram_addr, ram_wdata,
    input  ram_rdata, ram_ack
  );

  modport slave (
    input  ram_avalid, ram_rnw, ram_addr, ram_wdata,
    output ram_rdata, ram_ack
  );

endinterface

// File: rtl/ram_line_responder_store.sv
// Line array with per-line written flags; one shared address for the write port and the
// combinational read.
module ram_line_store
  import ram_if_pkg::*;
#(
  parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  clear_i,
  input  logic                  we_i,
  input  logic [ADDR_SIZE-1:0]  addr_i,
  input  logic [LINE_WIDTH-1:0] wline_i,
  output logic [LINE_WIDTH-1:0] rline_o,
  output logic                  rvalid_o
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  logic [LINE_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[addr_i] <= 1'b1;
    end
  end

  // Contents are left alone on clear; the flags alone decide whether a line is trusted.
  always_ff @(posedge clk_i) begin
    if (we_i && !clear_i) begin
      mem_q[addr_i] <= wline_i;
    end
  end

  assign rline_o  = mem_q[addr_i];
  assign rvalid_o = valid_q[addr_i];

endmodule

// File: rtl/ram_line_responder.sv
// Synthesizable RAM-side responder: collects written lines beat by beat and returns
// stored (or address-pattern) lines as an acknowledged burst after a fixed latency.
module ram_line_responder
  import ram_if_pkg::*;
#(
  parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int LATENCY    = 2
) (
  input  logic                  ram_clk,
  input  logic                  ram_rst_n,
  ram_line_responder_if.slave   ram,
  output logic [LINE_WIDTH-1:0] data_backdoor
);

  localparam int BEATS  = beats_of(LINE_WIDTH, WORD_SIZE);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [LAT_W-1:0]  LAST_WAIT = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  ram_state_e            state_q;
  logic [ADDR_SIZE-1:0]  addr_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [LAT_W-1:0]      latCnt_q;
  logic [LINE_WIDTH-1:0] lineBuf_q;
  logic                  ack_q;
  logic [WORD_SIZE-1:0]  rdata_q;
  logic [LINE_WIDTH-1:0] backdoor_q;

  logic [ADDR_SIZE-1:0]  accessAddr;
  logic [BEAT_W-1:0]     wrIdx;
  logic [BEAT_W-1:0]     rdIdx;
  logic [LINE_WIDTH-1:0] wrLine_d;
  logic [WORD_SIZE-1:0]  rdBeat_d;
  logic                  writeFire;
  logic [LINE_WIDTH-1:0] storeLine;
  logic                  storeValid;

  // In IDLE the live request address is used so zero-latency reads and one-beat writes
  // can act on the capture edge itself.
  always_comb begin
    accessAddr = (state_q == IDLE) ? ram.ram_addr : addr_q;
    wrIdx      = (state_q == IDLE) ? '0 : beat_q;
    rdIdx      = (state_q == RD_BURST) ? beat_q + BEAT_W'(1) : '0;
    wrLine_d   = (lineBuf_q & ~(LINE_WIDTH'({WORD_SIZE{1'b1}}) << (WORD_SIZE * int'(wrIdx))))
               | (LINE_WIDTH'(ram.ram_wdata) << (WORD_SIZE * int'(wrIdx)));
    rdBeat_d   = storeValid
               ? WORD_SIZE'(storeLine >> (WORD_SIZE * int'(rdIdx)))
               : WORD_SIZE'(pattern_beat(64'(accessAddr), 2'(rdIdx), ADDR_SIZE));
    writeFire  = ((state_q == WR_COLLECT) && (beat_q == LAST_BEAT))
              || ((state_q == IDLE) && ram.ram_avalid && !ram.ram_rnw && (BEATS == 1));
  end

  ram_line_store #(
    .ADDR_SIZE (ADDR_SIZE),
    .LINE_WIDTH(LINE_WIDTH)
  ) uStore (
    .clk_i   (ram_clk),
    .clear_i (!ram_rst_n),
    .we_i    (writeFire),
    .addr_i  (accessAddr),
    .wline_i (wrLine_d),
    .rline_o (storeLine),
    .rvalid_o(storeValid)
  );

  always_ff @(posedge ram_clk) begin
    if (!ram_rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      beat_q     <= '0;
      latCnt_q   <= '0;
      lineBuf_q  <= '0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      backdoor_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q   <= 1'b0;
          rdata_q <= '0;
          if (ram.ram_avalid) begin
            addr_q   <= ram.ram_addr;
            latCnt_q <= '0;
            beat_q   <= '0;
            if (!ram.ram_rnw) begin
              lineBuf_q <= wrLine_d;
              if (BEATS == 1) begin
                state_q    <= WR_ACK;
                ack_q      <= 1'b1;
                backdoor_q <= wrLine_d;
              end else begin
                state_q <= WR_COLLECT;
                beat_q  <= BEAT_W'(1);
              end
            end else if (LATENCY == 0) begin
              state_q <= RD_BURST;
              ack_q   <= 1'b1;
              rdata_q <= rdBeat_d;
            end else begin
              state_q <= RD_WAIT;
            end
          end
        end
        WR_COLLECT: begin
          lineBuf_q <= wrLine_d;
          beat_q    <= beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_q    <= WR_ACK;
            ack_q      <= 1'b1;
            backdoor_q <= wrLine_d;
          end
        end
        WR_ACK: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
        RD_WAIT: begin
          if (latCnt_q == LAST_WAIT) begin
            state_q <= RD_BURST;
            ack_q   <= 1'b1;
            rdata_q <= rdBeat_d;
            beat_q  <= '0;
          end else begin
            latCnt_q <= latCnt_q + LAT_W'(1);
          end
        end
        RD_BURST: begin
          if (beat_q == LAST_BEAT) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            rdata_q <= '0;
          end else begin
            rdata_q <= rdBeat_d;
            beat_q  <= beat_q + BEAT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
          rdata_q <= '0;
        end
      endcase
    end
  end

  assign ram.ram_ack   = ack_q;
  assign ram.ram_rdata = rdata_q;
  assign data_backdoor = backdoor_q;

endmodule

// File: tb/tb_ram_line_responder.sv
// Scoreboard bench for ram_line_responder: a LATENCY=2 instance for most scenarios and a
// LATENCY=0 instance for the zero-wait read path.
module tb_ram_line_responder;

  typedef struct packed {
    logic        isRead;
    logic [63:0] data;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_line_responder_if #(.ADDR_SIZE(13), .WORD_SIZE(16)) bus0 ();
  ram_line_responder_if #(.ADDR_SIZE(13), .WORD_SIZE(16)) bus1 ();
  logic [63:0] backdoor0;
  logic [63:0] backdoor1;

  ram_line_responder #(.ADDR_SIZE(13), .WORD_SIZE(16), .LINE_WIDTH(64), .LATENCY(2)) dut0 (
    .ram_clk(clk), .ram_rst_n(rst_n), .ram(bus0), .data_backdoor(backdoor0)
  );

  ram_line_responder #(.ADDR_SIZE(13), .WORD_SIZE(16), .LINE_WIDTH(64), .LATENCY(0)) dut1 (
    .ram_clk(clk), .ram_rst_n(rst_n), .ram(bus1), .data_backdoor(backdoor1)
  );

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    reqCyc = 0;
  int    riseCyc0 = -100;
  int    riseCyc1 = -100;
  int    ackCnt0 = 0;
  int    ackCnt1 = 0;
  bit    prevAck0 = 1'b0;
  bit    prevAck1 = 1'b0;
  item_t expQ0[$];
  item_t expQ1[$];
  logic [63:0] modelMem [int];

  always @(posedge clk) cyc++;

  // Expected beat: the last written line if any, otherwise {k[1:0], 0, addr}.
  function automatic logic [15:0] expBeat(input logic [12:0] addr, input int k);
    logic [63:0] ln;
    logic [1:0]  kk;
    kk = k[1:0];
    if (modelMem.exists(int'(addr))) begin
      ln = modelMem[int'(addr)];
      return ln[16*k +: 16];
    end
    return {kk, 1'b0, addr};
  endfunction

  always @(negedge clk) begin : mon0
    item_t it;
    if (bus0.ram_ack === 1'b1) begin
      ackCnt0++;
      if (!prevAck0) riseCyc0 = cyc;
      total++;
      if (expQ0.size() == 0) begin
        bad++;
        $display("[TB] FAIL u0_unexpected_ack got=ack rdata=%h want=no_ack", bus0.ram_rdata);
      end else begin
        it = expQ0.pop_front();
        if (it.isRead && bus0.ram_rdata !== it.data[15:0]) begin
          bad++;
          $display("[TB] FAIL u0_rdata got=%h want=%h", bus0.ram_rdata, it.data[15:0]);
        end else if (!it.isRead && backdoor0 !== it.data) begin
          bad++;
          $display("[TB] FAIL u0_backdoor got=%h want=%h", backdoor0, it.data);
        end
      end
    end
    prevAck0 = (bus0.ram_ack === 1'b1);
  end

  always @(negedge clk) begin : mon1
    item_t it;
    if (bus1.ram_ack === 1'b1) begin
      ackCnt1++;
      if (!prevAck1) riseCyc1 = cyc;
      total++;
      if (expQ1.size() == 0) begin
        bad++;
        $display("[TB] FAIL u1_unexpected_ack got=ack rdata=%h want=no_ack", bus1.ram_rdata);
      end else begin
        it = expQ1.pop_front();
        if (bus1.ram_rdata !== it.data[15:0]) begin
          bad++;
          $display("[TB] FAIL u1_rdata got=%h want=%h", bus1.ram_rdata, it.data[15:0]);
        end
      end
    end
    prevAck1 = (bus1.ram_ack === 1'b1);
  end

  // Issues a read at the current falling edge and queues the four expected beats.
  task automatic startRead(input bit sel, input logic [12:0] addr);
    item_t it;
    for (int k = 0; k < 4; k++) begin
      it.isRead = 1'b1;
      it.data   = 64'(expBeat(addr, k));
      if (sel) expQ1.push_back(it);
      else     expQ0.push_back(it);
    end
    if (sel) begin
      riseCyc1 = -100;
      bus1.ram_avalid = 1'b1; bus1.ram_rnw = 1'b1; bus1.ram_addr = addr;
    end else begin
      riseCyc0 = -100;
      bus0.ram_avalid = 1'b1; bus0.ram_rnw = 1'b1; bus0.ram_addr = addr;
    end
    reqCyc = cyc;
    @(negedge clk);
    bus0.ram_avalid = 1'b0;
    bus1.ram_avalid = 1'b0;
  endtask

  // Streams a full line into dut0; returns on the falling edge where the ack is due.
  task automatic doWrite(input logic [12:0] addr, input logic [63:0] line);
    item_t it;
    it.isRead = 1'b0;
    it.data   = line;
    expQ0.push_back(it);
    modelMem[int'(addr)] = line;
    riseCyc0 = -100;
    bus0.ram_avalid = 1'b1; bus0.ram_rnw = 1'b0; bus0.ram_addr = addr;
    bus0.ram_wdata = line[15:0];
    reqCyc = cyc;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      bus0.ram_avalid = 1'b0;
      bus0.ram_wdata  = line[16*k +: 16];
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus0.ram_ack !== 1'b0) begin bad++; $display("[TB] FAIL rst_ack0 got=%b want=0", bus0.ram_ack); end
    total++; if (bus0.ram_rdata !== 16'h0) begin bad++; $display("[TB] FAIL rst_rdata0 got=%h want=0", bus0.ram_rdata); end
    total++; if (backdoor0 !== 64'h0) begin bad++; $display("[TB] FAIL rst_backdoor0 got=%h want=0", backdoor0); end
    total++; if (bus1.ram_ack !== 1'b0) begin bad++; $display("[TB] FAIL rst_ack1 got=%b want=0", bus1.ram_ack); end
    total++; if (bus1.ram_rdata !== 16'h0) begin bad++; $display("[TB] FAIL rst_rdata1 got=%h want=0", bus1.ram_rdata); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_pattern();
    int n0 = ackCnt0;
    startRead(1'b0, 13'h0101);
    for (int i = 0; i < 20 && expQ0.size() != 0; i++) @(negedge clk);
    total++; if (expQ0.size() != 0) begin bad++; $display("[TB] FAIL rd0101_drain got=%0d left want=0", expQ0.size()); end
    total++; if (riseCyc0 - reqCyc != 3) begin bad++; $display("[TB] FAIL rd0101_latency got=%0d want=3", riseCyc0 - reqCyc); end
    total++; if (ackCnt0 - n0 != 4) begin bad++; $display("[TB] FAIL rd0101_acks got=%0d want=4", ackCnt0 - n0); end
    @(negedge clk);
    total++; if (bus0.ram_ack !== 1'b0) begin bad++; $display("[TB] FAIL rd0101_end_ack got=%b want=0", bus0.ram_ack); end
    total++; if (bus0.ram_rdata !== 16'h0) begin bad++; $display("[TB] FAIL rd0101_end_rdata got=%h want=0", bus0.ram_rdata); end
  endtask

  task automatic test_write_readback();
    doWrite(13'h0181, 64'h300020001000F83F);
    @(negedge clk);
    total++; if (riseCyc0 - reqCyc != 4) begin bad++; $display("[TB] FAIL wr0181_ack_cycle got=%0d want=4", riseCyc0 - reqCyc); end
    total++; if (bus0.ram_ack !== 1'b0) begin bad++; $display("[TB] FAIL wr0181_pulse got=%b want=0", bus0.ram_ack); end
    total++; if (backdoor0 !== 64'h300020001000F83F) begin bad++; $display("[TB] FAIL wr0181_backdoor got=%h want=300020001000f83f", backdoor0); end
    startRead(1'b0, 13'h0181);
    for (int i = 0; i < 20 && expQ0.size() != 0; i++) @(negedge clk);
    total++; if (expQ0.size() != 0) begin bad++; $display("[TB] FAIL rd0181_drain got=%0d left want=0", expQ0.size()); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    doWrite(13'h1F03, 64'hDEADBEEFCAFE1234);
    @(negedge clk);
    startRead(1'b0, 13'h1F03);
    for (int i = 0; i < 20 && expQ0.size() != 0; i++) @(negedge clk);
    total++; if (expQ0.size() != 0) begin bad++; $display("[TB] FAIL b2b_drain got=%0d left want=0", expQ0.size()); end
    total++; if (riseCyc0 - reqCyc != 3) begin bad++; $display("[TB] FAIL b2b_latency got=%0d want=3", riseCyc0 - reqCyc); end
    @(negedge clk);
    startRead(1'b0, 13'h1F04);
    for (int i = 0; i < 20 && expQ0.size() != 0; i++) @(negedge clk);
    total++; if (expQ0.size() != 0) begin bad++; $display("[TB] FAIL rd1f04_drain got=%0d left want=0", expQ0.size()); end
    @(negedge clk);
  endtask

  task automatic test_ignored_requests();
    int n0 = ackCnt0;
    startRead(1'b0, 13'h0181);
    bus0.ram_avalid = 1'b1; bus0.ram_rnw = 1'b1; bus0.ram_addr = 13'h0300;
    @(negedge clk);
    bus0.ram_avalid = 1'b0;
    repeat (2) @(negedge clk);
    bus0.ram_avalid = 1'b1; bus0.ram_rnw = 1'b0; bus0.ram_addr = 13'h0300; bus0.ram_wdata = 16'hFFFF;
    @(negedge clk);
    bus0.ram_avalid = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (expQ0.size() != 0) begin bad++; $display("[TB] FAIL ign_drain got=%0d left want=0", expQ0.size()); end
    total++; if (ackCnt0 - n0 != 4) begin bad++; $display("[TB] FAIL ign_acks got=%0d want=4", ackCnt0 - n0); end
    total++; if (riseCyc0 - reqCyc != 3) begin bad++; $display("[TB] FAIL ign_latency got=%0d want=3", riseCyc0 - reqCyc); end
  endtask

  task automatic test_reset_abort();
    int n0 = ackCnt0;
    bus0.ram_avalid = 1'b1; bus0.ram_rnw = 1'b0; bus0.ram_addr = 13'h0002; bus0.ram_wdata = 16'h1111;
    @(negedge clk);
    bus0.ram_avalid = 1'b0; bus0.ram_wdata = 16'h2222;
    rst_n = 1'b0;
    modelMem.delete();
    @(negedge clk);
    bus0.ram_wdata = 16'h3333;
    @(negedge clk);
    bus0.ram_wdata = 16'h4444;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (ackCnt0 - n0 != 0) begin bad++; $display("[TB] FAIL abort_acks got=%0d want=0", ackCnt0 - n0); end
    total++; if (backdoor0 !== 64'h0) begin bad++; $display("[TB] FAIL abort_backdoor got=%h want=0", backdoor0); end
    startRead(1'b0, 13'h0002);
    for (int i = 0; i < 20 && expQ0.size() != 0; i++) @(negedge clk);
    total++; if (expQ0.size() != 0) begin bad++; $display("[TB] FAIL abort_rd0002_drain got=%0d left want=0", expQ0.size()); end
    @(negedge clk);
    startRead(1'b0, 13'h0181);
    for (int i = 0; i < 20 && expQ0.size() != 0; i++) @(negedge clk);
    total++; if (expQ0.size() != 0) begin bad++; $display("[TB] FAIL abort_rd0181_drain got=%0d left want=0", expQ0.size()); end
    @(negedge clk);
  endtask

  task automatic test_latency0();
    int n1 = ackCnt1;
    startRead(1'b1, 13'h0ABC);
    for (int i = 0; i < 20 && expQ1.size() != 0; i++) @(negedge clk);
    total++; if (expQ1.size() != 0) begin bad++; $display("[TB] FAIL lat0_drain got=%0d left want=0", expQ1.size()); end
    total++; if (riseCyc1 - reqCyc != 1) begin bad++; $display("[TB] FAIL lat0_latency got=%0d want=1", riseCyc1 - reqCyc); end
    total++; if (ackCnt1 - n1 != 4) begin bad++; $display("[TB] FAIL lat0_acks got=%0d want=4", ackCnt1 - n1); end
    @(negedge clk);
    total++; if (bus1.ram_ack !== 1'b0) begin bad++; $display("[TB] FAIL lat0_end_ack got=%b want=0", bus1.ram_ack); end
    total++; if (bus1.ram_rdata !== 16'h0) begin bad++; $display("[TB] FAIL lat0_end_rdata got=%h want=0", bus1.ram_rdata); end
  endtask

  initial begin
    bus0.ram_avalid = 1'b0; bus0.ram_rnw = 1'b0; bus0.ram_addr = '0; bus0.ram_wdata = '0;
    bus1.ram_avalid = 1'b0; bus1.ram_rnw = 1'b0; bus1.ram_addr = '0; bus1.ram_wdata = '0;
    $display("[TB] starting ram_line_responder bench");
    test_reset();
    test_read_pattern();
    test_write_readback();
    test_back_to_back();
    test_ignored_requests();
    test_reset_abort();
    test_latency0();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout got=running want=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/ram_line_responder.md
Name: ram_line_responder

Overview:
Synthesizable responder for the cache-to-RAM line interface. It replaces the behavioural RAM stub on the cache's RAM side.
- Accepts one line request per transaction.
- Writes: collects the line as a stream of WORD_SIZE beats and stores it.
- Reads: after a fixed latency, returns the line as an acknowledged burst of beats.
- Runs entirely in the RAM clock domain. Lines never written since reset return a deterministic address-derived pattern.

Parameters:
ADDR_SIZE, 13, line address width (tag+index)
WORD_SIZE, 16, beat width on ram_wdata/ram_rdata
LINE_WIDTH, 64, cache line width; BEATS = LINE_WIDTH/WORD_SIZE (must be an integer >= 1)
LATENCY, 2, idle cycles between read request capture and first read beat (0 allowed)

Ports:
ram_clk  in  1  clock; all logic on rising edge
ram_rst_n  in  1  reset, synchronous, active-low
ram_avalid  in  1  request strobe, sampled only in IDLE
ram_rnw  in  1  1 = read line, 0 = write line; sampled with ram_avalid
ram_addr  in  ADDR_SIZE  line address; sampled with ram_avalid
ram_wdata  in  WORD_SIZE  write beat; beat 0 comes with ram_avalid, beats 1..BEATS-1 on the following consecutive cycles
ram_rdata  out  WORD_SIZE  read beat; valid while ram_ack=1 in a read burst
ram_ack  out  1  read: high for BEATS consecutive cycles; write: single-cycle completion pulse
data_backdoor  out  LINE_WIDTH  last fully written line (debug/verification observation)

Behaviour:
- Reset (ram_rst_n=0 at a rising edge):
  - state <= IDLE; ram_ack, ram_rdata, data_backdoor <= 0.
  - All per-line written-valid bits cleared. Array contents are don't-care.
  - Reset mid-transaction aborts it: no array update, no further acks.
- Beat k occupies line bits [k*WORD_SIZE +: WORD_SIZE]. Beat 0 is the LSB beat and is transferred first.
- Unwritten-line pattern, beat k = {k[1:0], 1'b0, addr} (with default widths); zero-extend or truncate to WORD_SIZE otherwise.
- States: IDLE, WR_COLLECT, WR_ACK, RD_WAIT, RD_BURST. Beat counter is log2(BEATS) bits; latency counter is sized for LATENCY.
- IDLE: ram_ack=0.
  - ram_avalid=1 at edge T: latch addr and rnw.
  - Write with BEATS>1: store beat 0 and go to WR_COLLECT.
  - Write with BEATS=1: go straight to WR_ACK.
  - Read: go to RD_WAIT if LATENCY>0, otherwise RD_BURST.
- WR_COLLECT: capture ram_wdata at edges T+1..T+BEATS-1 with no gaps. The initiator must hold the stream; there is no backpressure. After the last beat, go to WR_ACK.
- WR_ACK (cycle T+BEATS):
  - ram_ack=1 for exactly one cycle.
  - At the edge entering this state: array[addr] <= assembled line, valid[addr] <= 1, data_backdoor <= line.
  - Next state: IDLE.
- RD_WAIT: count LATENCY cycles (T+1..T+LATENCY), then go to RD_BURST.
- RD_BURST: ram_ack=1 and ram_rdata = beat 0..BEATS-1 on cycles T+LATENCY+1 .. T+LATENCY+BEATS. Source is array[addr] if valid[addr], else the pattern. Then go to IDLE; ram_ack=0 and ram_rdata <= 0.
- Outputs are registered. ram_ack/ram_rdata change only on ram_clk edges.
- ram_avalid outside IDLE is ignored and not queued. A request asserted on the cycle after the final ack is accepted (IDLE is entered for one cycle minimum).
- Write followed immediately by a read of the same addr returns the new data.
- ram_rnw and ram_addr are don't-care when ram_avalid=0.

Decomposition:
- Package ram_if_pkg:
  - state enum (IDLE, WR_COLLECT, WR_ACK, RD_WAIT, RD_BURST);
  - BEATS derivation constant;
  - pattern_beat(addr, k) function;
  - default width constants (13/16/64).
- One sub-module, ram_line_store:
  - LINE_WIDTH x 2^ADDR_SIZE array plus valid-bit vector;
  - one write port; combinational read of line and valid;
  - synchronous clear of the valid bits.
- The FSM and beat/latency counters stay in the top module.

Test Plan:
- Reset, then read addr 0x0101 -> after 2 wait cycles, ram_ack high for 4 cycles with rdata 0x0101, 0x4101, 0x8101, 0xC101; then ack=0, rdata=0.
- Write addr 0x0181 with beats 0xF83F, 0x1000, 0x2000, 0x3000 -> single ack pulse on the 4th cycle after the request; data_backdoor = 64'h300020001000F83F; a read of 0x0181 returns the same four beats.
- Write addr 0x1F03, then immediately (cycle after ack) read 0x1F03 -> request accepted, written beats returned; a read of 0x1F04 still returns the pattern 0x1F04, 0x5F04, 0x9F04, 0xDF04.
- Pulse ram_avalid during RD_WAIT and RD_BURST -> ignored; exactly 4 acks; no second transaction.
- ram_rst_n=0 during WR_COLLECT of 0x0002 -> no ack; a subsequent read of 0x0002 returns the pattern and data_backdoor = 0; a previously written line 0x0181 reads as the pattern after reset.
- LATENCY=0 instance: read request at T -> ack and beat 0 at T+1, burst ends at T+4.
